dmem_arbiter_rmw: RTL and testbench



---
 rtl/dmem_arbiter_rmw.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter_rmw.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_rmw.sv
// Two-port arbiter/sequencer for a single-port data memory; sub-word stores become read-modify-write.
// Latency: misaligned ack in cycle 1, load/word store in cycle 2, sub-word store in cycle 3.
// Backpressure: a losing request waits with no ack; grants alternate when both ports keep requesting.
module dmem_arbiter_rmw #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [1:0]            size0,
  input  logic [MEM_AW+1:0]     addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [1:0]            size1,
  input  logic [MEM_AW+1:0]     addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  busy,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [MEM_AW+1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merged_q, merged_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;

  logic                  sel1;
  logic                  g_we;
  logic [1:0]            g_size;
  logic [MEM_AW+1:0]     g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic                  g_mis;
  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged_val;

  // Grant selection and datapath helpers: port 1 wins only if alone or if port 0 had the last grant.
  always_comb begin
    sel1      = req1 & (~req0 | ~last_grant_q);
    g_we      = sel1 ? we1 : we0;
    g_size    = sel1 ? size1 : size0;
    g_addr    = sel1 ? addr1 : addr0;
    g_wdata   = sel1 ? wdata1 : wdata0;
    g_mis     = (g_size == 2'b11) |
                ((g_size == 2'b01) & g_addr[0]) |
                ((g_size == 2'b10) & (g_addr[1:0] != 2'b00));
    sh        = {addr_q[1:0], 3'b000};
    shifted   = mem_rd >> sh;
    lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    case (size_q)
      2'b00:   load_data = shifted & 32'h0000_00FF;
      2'b01:   load_data = shifted & 32'h0000_FFFF;
      default: load_data = shifted;
    endcase
    merged_val = (mem_rd & ~(lane_mask << sh)) | ((wdata_q & lane_mask) << sh);
  end

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          port_d       = sel1;
          last_grant_d = sel1;
          we_d         = g_we;
          size_d       = g_size;
          addr_d       = g_addr;
          wdata_d      = g_wdata;
          rdata_d      = '0;
          err_d        = g_mis;
          state_d      = g_mis ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = load_data;
          state_d = DONE;
        end else if (size_q == 2'b10) begin
          state_d = DONE;
        end else begin
          merged_d = merged_val;
          state_d  = MERGE_WR;
        end
      end
      MERGE_WR: state_d = DONE;
      default: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    ack0_d = (state_d == DONE) & ~port_d;
    ack1_d = (state_d == DONE) & port_d;
  end

  // State and latched request fields; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      merged_q     <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  // Memory strobes decode straight from state so reset drops the write enable immediately.
  always_comb begin
    mem_we = (state_q == MERGE_WR) |
             ((state_q == ACCESS) & we_q & (size_q == 2'b10));
    mem_wd = (state_q == MERGE_WR) ? merged_q : wdata_q;
    mem_a  = addr_q[MEM_AW+1:2];
    busy   = (state_q != IDLE);
    ack0   = ack0_q;
    ack1   = ack1_q;
    rdata  = rdata_q;
    err    = err_q;
  end

endmodule

// File: tb/tb_dmem_arbiter_rmw.sv
// Directed bench for dmem_arbiter_rmw with a behavioural word memory.
// Latency is counted in clock edges from the first sampling of req.
// Requests are held until ack and dropped right after the ack cycle is seen.
module tb_dmem_arbiter_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [1:0]  size0, size1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, err, busy, mem_we;
  logic [31:0] rdata, mem_wd, mem_rd;
  logic [7:0]  mem_a;

  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [31:0] pl_d = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_rmw #(.DATA_WIDTH(32), .MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a];

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (mem_we) mem[mem_a] <= mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request on port p and wait for its ack; reports latency and observed flags.
  task automatic do_req(input string tag, input int p, input logic w, input logic [1:0] sz,
                        input logic [9:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic e,
                        output logic we_seen);
    logic acked, other;
    acked = 1'b0; other = 1'b0; we_seen = 1'b0; lat = 0; rd = '0; e = 1'b0;
    @(posedge clk); #1;
    if (p == 0) begin req0 = 1'b1; we0 = w; size0 = sz; addr0 = a; wdata0 = wd; end
    else        begin req1 = 1'b1; we1 = w; size1 = sz; addr1 = a; wdata1 = wd; end
    for (int k = 1; k <= 20 && !acked; k++) begin
      @(posedge clk); #1;
      we_seen = we_seen | mem_we;
      if ((p == 0) ? ack0 : ack1) begin
        acked = 1'b1; lat = k; rd = rdata; e = err;
        if ((p == 0) ? ack1 : ack0) other = 1'b1;
      end else if (ack0 | ack1) begin
        other = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk({tag, "_acked"}, 32'(acked), 32'd1);
    chk({tag, "_other_ack"}, 32'(other), 32'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        e, ws;
  int          n_ack;
  logic        both;
  int          order [4];
  logic [31:0] rds [4];

  initial begin
    rst_n = 1'b0;
    req0 = 0; we0 = 0; size0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; size1 = 0; addr1 = 0; wdata1 = 0;
    #12;
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_a", 32'(mem_a), 0);
    chk("rst_mem_wd", mem_wd, 0);
    rst_n = 1'b1;

    // Word store then word load on port 0.
    do_req("wst", 0, 1'b1, 2'b10, 10'h010, 32'hDEADBEEF, lat, rd, e, ws);
    chk("wst_lat", 32'(lat), 2);
    chk("wst_err", 32'(e), 0);
    chk("wst_mem", mem[4], 32'hDEADBEEF);
    do_req("wld", 0, 1'b0, 2'b10, 10'h010, 32'h0, lat, rd, e, ws);
    chk("wld_lat", 32'(lat), 2);
    chk("wld_rdata", rd, 32'hDEADBEEF);
    chk("wld_err", 32'(e), 0);

    // Byte RMW into lane 2, then sub-word loads of the merged word.
    preload(8'd4, 32'h11223344);
    do_req("bst", 0, 1'b1, 2'b00, 10'h012, 32'h000000AA, lat, rd, e, ws);
    chk("bst_lat", 32'(lat), 3);
    chk("bst_rdata", rd, 0);
    chk("bst_mem", mem[4], 32'h11AA3344);
    do_req("hld", 0, 1'b0, 2'b01, 10'h012, 32'h0, lat, rd, e, ws);
    chk("hld_lat", 32'(lat), 2);
    chk("hld_rdata", rd, 32'h000011AA);
    do_req("bld", 1, 1'b0, 2'b00, 10'h013, 32'h0, lat, rd, e, ws);
    chk("bld_rdata", rd, 32'h00000011);
    do_req("hst", 1, 1'b1, 2'b01, 10'h010, 32'h1234BEEF, lat, rd, e, ws);
    chk("hst_lat", 32'(lat), 3);
    chk("hst_mem", mem[4], 32'h11AABEEF);

    // Misaligned and reserved-size accesses.
    preload(8'd1, 32'hCAFEF00D);
    do_req("mis_w", 0, 1'b1, 2'b10, 10'h006, 32'h12345678, lat, rd, e, ws);
    chk("mis_w_lat", 32'(lat), 1);
    chk("mis_w_err", 32'(e), 1);
    chk("mis_w_we_seen", 32'(ws), 0);
    chk("mis_w_mem", mem[1], 32'hCAFEF00D);
    do_req("rsv", 0, 1'b0, 2'b11, 10'h004, 32'h0, lat, rd, e, ws);
    chk("rsv_lat", 32'(lat), 1);
    chk("rsv_err", 32'(e), 1);
    chk("rsv_rdata", rd, 0);
    do_req("mis_h", 1, 1'b0, 2'b01, 10'h011, 32'h0, lat, rd, e, ws);
    chk("mis_h_err", 32'(e), 1);
    chk("mis_h_rdata", rd, 0);

    // Both ports requesting continuously from reset: grants alternate starting with port 0.
    @(posedge clk); #1;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin order[i] = 9; rds[i] = '0; end
    req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; addr0 = 10'h010;
    req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; addr1 = 10'h004;
    n_ack = 0; both = 1'b0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(posedge clk); #1;
      if (ack0 && ack1) both = 1'b1;
      else if (ack0) begin order[n_ack] = 0; rds[n_ack] = rdata; n_ack++; end
      else if (ack1) begin order[n_ack] = 1; rds[n_ack] = rdata; n_ack++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("arb_count", 32'(n_ack), 4);
    chk("arb_both_ack", 32'(both), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb_order%0d", i), 32'(order[i]), 32'(i % 2));
      chk($sformatf("arb_rdata%0d", i), rds[i], (i % 2 == 0) ? 32'h11AABEEF : 32'hCAFEF00D);
    end

    // Reset while the RMW write is being presented.
    preload(8'd5, 32'h55667788);
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; size1 = 2'b00; addr1 = 10'h015; wdata1 = 32'h000000A5;
    @(posedge clk); #1;
    chk("rmw_access_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    chk("rmw_merge_we", 32'(mem_we), 1);
    chk("rmw_merge_wd", mem_wd, 32'h5566A588);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_we", 32'(mem_we), 0);
    chk("rmw_rst_ack0", 32'(ack0), 0);
    chk("rmw_rst_ack1", 32'(ack1), 0);
    chk("rmw_rst_busy", 32'(busy), 0);
    req1 = 1'b0;
    @(posedge clk); #1;
    chk("rmw_rst_mem", mem[5], 32'h55667788);
    rst_n = 1'b1;
    do_req("post_rst", 0, 1'b0, 2'b10, 10'h014, 32'h0, lat, rd, e, ws);
    chk("post_rst_lat", 32'(lat), 2);
    chk("post_rst_rdata", rd, 32'h55667788);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
